// File: rtl/metronomo_ctrl.sv
// Metronome beat scheduler: debounced up/down/run buttons, bounded BPM register and a
// phase accumulator that emits one beat strobe per 60*CLK_HZ of accumulated BPM.
//
// state | meaning
// STOP  | idle, no beats, accumulator held at 0
// RUN   | accumulator advances by bpm each cycle, beat on each wrap past TOP

module metronomo_ctrl #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BPM_MIN    = 40,
  parameter int unsigned BPM_MAX    = 240,
  parameter int unsigned BPM_DEF    = 60,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_run_n,
  output logic       beat,
  output logic [7:0] bpm,
  output logic       running
);

  localparam int unsigned   CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [32:0]   TOP      = 33'(CLK_HZ) * 33'd60;
  localparam logic [7:0]    BMIN     = 8'(BPM_MIN);
  localparam logic [7:0]    BMAX     = 8'(BPM_MAX);
  localparam logic [7:0]    BDEF     = 8'(BPM_DEF);

  typedef enum logic {STOP, RUN} state_t;
  state_t state;

  // bit 0 = up, bit 1 = down, bit 2 = run
  logic [2:0]    btn_raw, sync1, sync2, deb, deb_d, press;
  logic [CW-1:0] cnt [3];
  logic [31:0]   acc;
  logic [32:0]   sum;

  assign btn_raw = {btn_run_n, btn_down_n, btn_up_n};
  assign press   = deb_d & ~deb;
  assign sum     = {1'b0, acc} + {25'd0, bpm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      deb_d <= '1;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STOP;
      running <= 1'b0;
      beat    <= 1'b0;
      acc     <= '0;
      bpm     <= BDEF;
    end else begin
      beat <= 1'b0;
      case (state)
        STOP: begin
          if (press[2]) begin
            state   <= RUN;
            running <= 1'b1;
            acc     <= '0;
            beat    <= 1'b1;
          end
        end
        RUN: begin
          if (press[2]) begin
            state   <= STOP;
            running <= 1'b0;
            acc     <= '0;
          end else if (sum >= TOP) begin
            acc  <= 32'(sum - TOP);
            beat <= 1'b1;
          end else begin
            acc <= sum[31:0];
          end
        end
        default: begin
          state   <= STOP;
          running <= 1'b0;
          acc     <= '0;
        end
      endcase
      // accumulator above still used the old bpm this cycle
      if (press[0] && !press[1]) begin
        if (bpm < BMAX) bpm <= bpm + 8'd1;
      end else if (press[1] && !press[0]) begin
        if (bpm > BMIN) bpm <= bpm - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_metronomo_ctrl.sv
// Bench for metronomo_ctrl: directed scenarios with literal expectations plus random
// button traffic, all cycles compared against a phase-count reference model.

module tb_metronomo_ctrl;

  localparam int     CLK_HZ = 100;
  localparam int     DEB    = 4;
  localparam int     BMIN   = 40;
  localparam int     BMAX   = 240;
  localparam int     BDEF   = 60;
  localparam longint TOP    = 60 * CLK_HZ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up_n = 1'b1;
  logic       btn_down_n = 1'b1;
  logic       btn_run_n = 1'b1;
  logic       beat;
  logic       running;
  logic [7:0] bpm;

  metronomo_ctrl #(
    .CLK_HZ(CLK_HZ), .BPM_MIN(BMIN), .BPM_MAX(BMAX), .BPM_DEF(BDEF), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
    .btn_run_n(btn_run_n), .beat(beat), .bpm(bpm), .running(running)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: a button level is accepted once the synchronized input has
  // disagreed with it for the last DEB samples; beats mark each crossing of a
  // multiple of TOP by the total BPM phase accumulated since the run started.
  int     m_bpm;
  bit     m_run, m_beat;
  longint m_phase;
  bit     d1 [3];
  bit     d2 [3];
  bit     mdeb [3];
  bit     fell [3];
  bit     win [3][$];

  initial forever begin : model
    bit raw [3];
    bit prs [3];
    bit syn, flip;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_bpm = BDEF; m_run = 0; m_beat = 0; m_phase = 0;
      for (int b = 0; b < 3; b++) begin
        d1[b] = 1; d2[b] = 1; mdeb[b] = 1; fell[b] = 0;
        win[b].delete();
      end
    end else begin
      raw[0] = btn_up_n; raw[1] = btn_down_n; raw[2] = btn_run_n;
      for (int b = 0; b < 3; b++) begin
        syn = d2[b]; d2[b] = d1[b]; d1[b] = raw[b];
        prs[b] = fell[b]; fell[b] = 0;
        win[b].push_back(syn);
        if (win[b].size() > DEB) void'(win[b].pop_front());
        flip = (win[b].size() == DEB);
        for (int k = 0; k < win[b].size(); k++)
          if (win[b][k] == mdeb[b]) flip = 0;
        if (flip) begin
          fell[b] = mdeb[b];
          mdeb[b] = syn;
        end
      end
      m_beat = 0;
      if (prs[2]) begin
        m_run = !m_run;
        m_phase = 0;
        m_beat = m_run;
      end else if (m_run) begin
        m_beat = ((m_phase + m_bpm) / TOP) != (m_phase / TOP);
        m_phase += m_bpm;
      end
      if (prs[0] && !prs[1]) m_bpm = (m_bpm < BMAX) ? m_bpm + 1 : BMAX;
      else if (prs[1] && !prs[0]) m_bpm = (m_bpm > BMIN) ? m_bpm - 1 : BMIN;
    end
  end

  initial forever begin : compare
    @(negedge clk);
    chk("beat", int'(beat), int'(m_beat));
    chk("bpm", int'(bpm), m_bpm);
    chk("running", int'(running), int'(m_run));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input bit v);
    case (b)
      0: btn_up_n = v;
      1: btn_down_n = v;
      default: btn_run_n = v;
    endcase
  endtask

  task automatic press_btn(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      set_btn(b, 1'b0); tick(6);
      set_btn(b, 1'b1); tick(6);
    end
  endtask

  // drives run low and reports the cycle count until running rises (-1 on timeout)
  task automatic start_run(output int lat);
    lat = -1;
    set_btn(2, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (running) begin lat = i; break; end
    end
  endtask

  initial begin : stim
    int lat, nbeat, first;
    int tb0, tb1;
    int hold [3];
    bit lvl;

    tick(3);
    chk("rst_bpm", int'(bpm), 60);
    chk("rst_running", int'(running), 0);
    chk("rst_beat", int'(beat), 0);
    rst_n = 1'b1;
    tick(2);

    // debounce: short glitch ignored, stable press lands 7 cycles after the edge
    set_btn(0, 1'b0); tick(3); set_btn(0, 1'b1); tick(20);
    chk("glitch_bpm", int'(bpm), 60);
    set_btn(0, 1'b0); tick(6);
    chk("lat6_bpm", int'(bpm), 60);
    tick(1);
    chk("lat7_bpm", int'(bpm), 61);
    tick(3); set_btn(0, 1'b1); tick(20);
    chk("once_bpm", int'(bpm), 61);
    press_btn(1, 1);
    chk("down_bpm", int'(bpm), 60);

    // first run: downbeat then a beat every 100 cycles
    start_run(lat);
    chk("run_latency", lat, 7);
    chk("downbeat", int'(beat), 1);
    nbeat = 0; first = -1;
    for (int t = 1; t <= 900; t++) begin
      @(negedge clk);
      if (t == 5) set_btn(2, 1'b1);
      if (beat) begin
        nbeat++;
        if (first < 0) first = t;
      end
    end
    chk("first_gap", first, 100);
    chk("beats_total", nbeat + 1, 10);

    // 60 -> 61 BPM at cycle 950, phase 3000: beats at 1000 then 1098
    tb0 = -1; tb1 = -1; nbeat = 0;
    for (int t = 901; t <= 1100; t++) begin
      @(negedge clk);
      if (t == 943) set_btn(0, 1'b0);
      if (t == 955) set_btn(0, 1'b1);
      if (beat) begin
        nbeat++;
        if (tb0 < 0) tb0 = t; else if (tb1 < 0) tb1 = t;
      end
    end
    chk("tempo_count", nbeat, 2);
    chk("tempo_beat1", tb0, 1000);
    chk("tempo_beat2", tb1, 1098);
    chk("tempo_bpm", int'(bpm), 61);

    // stop: silence for 1000 cycles
    press_btn(2, 1);
    nbeat = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (beat) nbeat++;
    end
    chk("stop_beats", nbeat, 0);
    chk("stop_running", int'(running), 0);

    start_run(lat);
    chk("restart_latency", lat, 7);
    chk("restart_downbeat", int'(beat), 1);
    tick(3); set_btn(2, 1'b1);

    // asynchronous reset mid-period
    tick(37);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("amid_beat", int'(beat), 0);
    chk("amid_running", int'(running), 0);
    chk("amid_bpm", int'(bpm), 60);
    tick(2); rst_n = 1'b1;
    nbeat = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (beat) nbeat++;
    end
    chk("post_rst_beats", nbeat, 0);
    chk("post_rst_running", int'(running), 0);

    // saturation and simultaneous presses
    press_btn(0, 200);
    chk("sat_hi", int'(bpm), 240);
    press_btn(0, 1);
    chk("sat_hi_hold", int'(bpm), 240);
    press_btn(1, 250);
    chk("sat_lo", int'(bpm), 40);
    press_btn(1, 1);
    chk("sat_lo_hold", int'(bpm), 40);
    press_btn(0, 1);
    set_btn(0, 1'b0); set_btn(1, 1'b0); tick(8);
    set_btn(0, 1'b1); set_btn(1, 1'b1); tick(8);
    chk("both_bpm", int'(bpm), 41);

    // 120 BPM: beats 50 cycles apart
    press_btn(0, 79);
    chk("bpm_120", int'(bpm), 120);
    start_run(lat);
    chk("run120_downbeat", int'(beat), 1);
    first = -1; nbeat = 0;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      if (t == 5) set_btn(2, 1'b1);
      if (beat) begin
        nbeat++;
        if (first < 0) first = t;
      end
    end
    chk("gap_120", first, 50);
    chk("beats_120", nbeat, 2);
    press_btn(2, 1);

    // random button traffic with occasional resets
    for (int b = 0; b < 3; b++) hold[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          lvl = 1'($urandom_range(0, 1));
          if (!lvl) hold[b] = int'($urandom_range(1, 10));
          else if (b == 2) hold[b] = int'($urandom_range(20, 250));
          else hold[b] = int'($urandom_range(1, 15));
          set_btn(b, lvl);
        end
        hold[b]--;
      end
      if (c % 1000 == 500) begin
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
      @(negedge clk);
    end
    set_btn(0, 1'b1); set_btn(1, 1'b1); set_btn(2, 1'b1);
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/metronomo_ctrl.md
# metronomo_ctrl

Beat scheduler for the metronome LED rotator. Debounces three push-buttons (up, down, start/stop) and holds the current BPM within limits. A phase accumulator turns the 50 MHz clock into a one-cycle `beat` strobe at exactly BPM beats per minute on average. `beat` is the advance enable of the LED rotator, and `bpm` feeds the BPM display decoder.

## Interface
- `CLK_HZ`, 50_000_000, clock frequency in Hz.
- `BPM_MIN`, 40, lowest selectable BPM.
- `BPM_MAX`, 240, highest selectable BPM; must be ≤ 255.
- `BPM_DEF`, 60, BPM loaded at reset; BPM_MIN ≤ BPM_DEF ≤ BPM_MAX.
- `DEB_CYCLES`, 1_000_000, consecutive stable cycles required to accept a button level (20 ms at 50 MHz).
- `clk`, in, 1, single system clock; all logic on its rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `btn_up_n`, in, 1, raw active-low button, asynchronous to clk; increments BPM.
- `btn_down_n`, in, 1, raw active-low button, asynchronous to clk; decrements BPM.
- `btn_run_n`, in, 1, raw active-low button, asynchronous to clk; toggles run/stop.
- `beat`, out, 1, one-cycle strobe, one per beat.
- `bpm`, out, 8, current BPM, unsigned.
- `running`, out, 1, high while in state RUN.

## Operation
- **Reset values** (`rst_n` low): `bpm` = BPM_DEF, `running` = 0, `beat` = 0, accumulator = 0, state STOP.
  - Debounced levels = 1 (released), debounce counters = 0, synchronizer flops = 1.
- **Input path**: each button passes a 2-flop synchronizer, then its own debouncer.
  - The debouncer counter runs while the synced level ≠ the debounced level, and clears when they match.
  - When the counter reaches DEB_CYCLES − 1, the debounced level takes the synced level and the counter clears.
  - `press_x` is a one-cycle pulse on each debounced 1→0 transition. Release generates nothing. Holding a button gives exactly one press.
- **BPM register**, updated on the cycle a press pulse is seen:
  - `press_up` alone: `bpm` + 1, saturating at BPM_MAX.
  - `press_down` alone: `bpm` − 1, saturating at BPM_MIN.
  - Both in the same cycle: no change.
  - BPM changes are accepted in both STOP and RUN.
- **FSM states**: STOP, RUN.
  - STOP → RUN on `press_run`: accumulator cleared to 0, downbeat scheduled.
  - RUN → STOP on `press_run`: accumulator cleared, no beat in that cycle or afterwards.
- **Accumulator**: 32-bit unsigned, TOP = 60·CLK_HZ (3_000_000_000 fits in 32 bits).
  - Each RUN cycle, except the entry cycle: sum = acc + bpm.
  - If sum ≥ TOP: acc ← sum − TOP and `beat` = 1.
  - Otherwise acc ← sum and `beat` = 0.
  - Compare in 33 bits so overflow cannot occur.
- **BPM change in RUN**: the accumulator keeps its phase, and the new increment applies from the cycle after `bpm` updates. There is no restart and no extra beat.

## Timing
- **Button latency**: a press reaches `bpm`/state 2 (sync) + DEB_CYCLES + 1 cycles after the raw edge, provided the input stays stable.
- **Bounce**: a glitch shorter than DEB_CYCLES produces no press.
- **Downbeat**: `beat` = 1 in the first cycle after the FSM enters RUN, i.e. the cycle after `press_run`.
- **Beat spacing**: the following beats are spaced ⌈(TOP − residue)/bpm⌉ cycles apart.
  - Long-run average period is TOP/bpm cycles, exactly CLK_HZ cycles at 60 BPM.
- **Output registers**: `beat` is registered and high for one cycle only. `running` and `bpm` are registered and glitch-free.
- **Reset mid-operation**: all outputs go to reset values immediately and asynchronously. No beat is emitted on release of reset.
- **Simultaneous `press_run` and a BPM press**: both take effect in the same cycle. The accumulator uses the new `bpm` from the next cycle.

## Test plan
Bench parameters: CLK_HZ=100 (TOP=6000), DEB_CYCLES=4, BPM_MIN=40, BPM_MAX=240, BPM_DEF=60.

1. **Reset and first beat**: after reset, check `bpm`=60, `running`=0, `beat`=0. Press run → `running`=1 and downbeat on the first RUN cycle, then beats every 100 cycles; 10 beats total across 900 cycles.
2. **Debounce**: a 3-cycle low glitch on `btn_up_n` leaves `bpm`=60. A 10-cycle press gives `bpm`=61 exactly once, 7 cycles after the edge.
3. **Saturation**: 200 up presses → `bpm`=240, then holds. 250 down presses → `bpm`=40, then holds. Simultaneous up and down → no change.
4. **Tempo change while running**: at 60 BPM, 50 cycles after a beat, set `bpm` to 120. The next beat arrives 25 cycles after the change, and later beats are 50 cycles apart, with no double beat.
5. **Stop/restart and reset mid-run**:
   - Press run while in RUN → `beat` stays 0 for 1000 cycles.
   - Restart → downbeat immediately.
   - Assert `rst_n` mid-period → outputs return to reset values, and no `beat` appears after release until run is pressed.
